// File: rtl/ultrasonic_ranger_ctrl_if.sv
// Sensor-side and result-side signals of the ultrasonic ranger controller.
interface ultrasonic_ranger_ctrl_if #(
  parameter int unsigned NUM_SENSORS = 2
);
  localparam int unsigned ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

  logic                   enable;
  logic                   start;
  logic [NUM_SENSORS-1:0] echo;
  logic [NUM_SENSORS-1:0] trig;
  logic                   busy;
  logic                   result_valid;
  logic [ID_W-1:0]        result_id;
  logic [31:0]            result_cycles;
  logic                   result_timeout;

  modport master (
    output enable, start, echo,
    input  trig, busy, result_valid, result_id, result_cycles, result_timeout
  );

  modport slave (
    input  enable, start, echo,
    output trig, busy, result_valid, result_id, result_cycles, result_timeout
  );
endinterface

// File: rtl/ultrasonic_ranger_ctrl.sv
// Round-robin HC-SR04 style ranger: trigger pulse, echo wait with arming,
// echo-high timing with saturation, one registered result per ping, holdoff.
module ultrasonic_ranger_ctrl #(
  parameter int unsigned NUM_SENSORS    = 2,
  parameter int unsigned TRIG_CYCLES    = 120,
  parameter int unsigned TIMEOUT_CYCLES = 360000,
  parameter int unsigned HOLDOFF_CYCLES = 720000
) (
  input  logic                     clk,
  input  logic                     rst,
  ultrasonic_ranger_ctrl_if.slave  bus
);

  localparam int unsigned ID_W      = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MEAS_SAT  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_REPORT,
    S_HOLDOFF
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_SENSORS-1:0] echo_m, echo_r;
  logic                   echo_s;
  logic [ID_W-1:0]        idx, idx_nxt;
  logic [31:0]            cnt, cnt_nxt;
  logic                   armed, armed_nxt;
  logic                   tmo, tmo_nxt;
  logic [NUM_SENSORS-1:0] trig_w;

  // Two-flop synchronizer on every echo pin; only the selected bit is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_m <= '0;
      echo_r <= '0;
    end else begin
      echo_m <= bus.echo;
      echo_r <= echo_m;
    end
  end

  // Synchronized echo of the currently scheduled sensor.
  always_comb echo_s = echo_r[idx];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    armed_nxt = armed;
    tmo_nxt   = tmo;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (bus.enable || bus.start) state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (cnt >= TRIG_LAST) begin
          state_nxt = S_WAIT_RISE;
          cnt_nxt   = '0;
          armed_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      S_WAIT_RISE: begin
        // A rise only counts once echo has been seen low during this wait,
        // so a stale high left over from a previous echo is ignored.
        armed_nxt = armed | ~echo_s;
        if (armed && echo_s) begin
          state_nxt = S_MEASURE;
          cnt_nxt   = 32'd1;
        end else if (cnt >= WAIT_LAST) begin
          state_nxt = S_REPORT;
          cnt_nxt   = '0;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      S_MEASURE: begin
        // cnt already includes the rising sample seen in WAIT_RISE; a high
        // sample arriving after cnt has reached the limit ends the ping.
        if (!echo_s) begin
          state_nxt = S_REPORT;
          tmo_nxt   = 1'b0;
        end else if (cnt >= MEAS_SAT) begin
          state_nxt = S_REPORT;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      S_REPORT: begin
        state_nxt = S_HOLDOFF;
        cnt_nxt   = '0;
      end
      S_HOLDOFF: begin
        if (cnt >= HOLD_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          idx_nxt   = (idx == ID_LAST) ? '0 : idx + ID_W'(1);
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter, arming flag, timeout flag and sensor index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
      tmo   <= 1'b0;
      idx   <= '0;
    end else begin
      cnt   <= cnt_nxt;
      armed <= armed_nxt;
      tmo   <= tmo_nxt;
      idx   <= idx_nxt;
    end
  end

  // Result registers: captured from REPORT, valid strobes for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result_valid   <= 1'b0;
      bus.result_id      <= '0;
      bus.result_cycles  <= '0;
      bus.result_timeout <= 1'b0;
    end else begin
      bus.result_valid <= (state == S_REPORT);
      if (state == S_REPORT) begin
        bus.result_id      <= idx;
        bus.result_cycles  <= cnt;
        bus.result_timeout <= tmo;
      end
    end
  end

  // Trigger decode straight from state so reset drops it asynchronously.
  always_comb begin
    trig_w = '0;
    if (state == S_TRIG) trig_w[idx] = 1'b1;
  end

  assign bus.trig = trig_w;
  assign bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Directed bench for ultrasonic_ranger_ctrl with a ping-level reference model.
module tb_ultrasonic_ranger_ctrl;

  localparam int NS   = 2;
  localparam int TRIG = 4;
  localparam int TMO  = 50;
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ultrasonic_ranger_ctrl_if #(.NUM_SENSORS(NS)) bus ();

  ultrasonic_ranger_ctrl #(
    .NUM_SENSORS(NS),
    .TRIG_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int id;
    int cycles;
    bit to;
    int at;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model state: expected sensor, last reported values, holdoff window.
  int              model_idx = 0;
  int              lastv     = 0;
  bit              have_v    = 1'b0;
  int              tw        = 0;
  int              last_tw   = 0;
  int              n_rise    = 0;
  int              last_id   = 0;
  int              last_cyc  = 0;
  bit              last_to   = 1'b0;
  logic [NS-1:0]   trig_prev = '0;
  res_t            e_c;
  res_t            o_c;

  // Per-cycle comparison of DUT outputs against the ping-level model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_trig", bus.trig, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_valid", bus.result_valid, 0);
      check("rst_id", bus.result_id, 0);
      check("rst_cycles", bus.result_cycles, 0);
      check("rst_timeout", bus.result_timeout, 0);
      have_v = 1'b0; model_idx = 0; trig_prev = '0; tw = 0;
      last_id = 0; last_cyc = 0; last_to = 1'b0;
    end else begin
      check("trig_onehot0", $countones(bus.trig) <= 1, 1);
      if (bus.trig != '0) begin
        check("busy_during_trig", bus.busy, 1);
        if (trig_prev == '0) begin
          n_rise++;
          check("trig_sensor", bus.trig, 1 << model_idx);
          if (have_v) check("holdoff_gap", (cyc - lastv) > HOLD, 1);
          tw = 1;
        end else begin
          tw++;
        end
      end else if (trig_prev != '0) begin
        check("trig_width", tw, TRIG);
        last_tw = tw;
      end
      trig_prev = bus.trig;
      if (have_v && (cyc - lastv) < HOLD)  check("busy_in_holdoff", bus.busy, 1);
      if (have_v && (cyc - lastv) == HOLD) check("idle_after_holdoff", bus.busy, 0);
      if (bus.result_valid) begin
        o_c.id = int'(bus.result_id); o_c.cycles = int'(bus.result_cycles);
        o_c.to = bus.result_timeout; o_c.at = cyc;
        obs_q.push_back(o_c);
        check("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_c = exp_q.pop_front();
          check("res_id", bus.result_id, e_c.id);
          check("res_cycles", bus.result_cycles, e_c.cycles);
          check("res_timeout", bus.result_timeout, e_c.to);
          check("res_time", cyc, e_c.at);
          last_id = e_c.id; last_cyc = e_c.cycles; last_to = e_c.to;
          model_idx = (e_c.id + 1) % NS;
        end
        have_v = 1'b1;
        lastv  = cyc;
      end else begin
        check("hold_id", bus.result_id, last_id);
        check("hold_cycles", bus.result_cycles, last_cyc);
        check("hold_timeout", bus.result_timeout, last_to);
        if (exp_q.size() > 0) begin
          check("valid_not_late", cyc <= exp_q[0].at, 1);
          if (cyc > exp_q[0].at) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_trig_rise(input int s);
    int n = 0;
    while (!bus.trig[s] && n < 2000) begin tick(); n++; end
    check("trig_rise_seen", bus.trig[s], 1);
  endtask

  task automatic wait_trig_fall(input int s, output int tf);
    int n = 0;
    while (bus.trig[s] && n < 200) begin tick(); n++; end
    check("trig_fall_seen", bus.trig[s], 0);
    tf = cyc;
  endtask

  task automatic wait_results(input int k);
    int n = 0;
    while (obs_q.size() < k && n < 3000) begin tick(); n++; end
    check("result_arrived", obs_q.size() >= k, 1);
  endtask

  task automatic wait_idle(output int ic);
    int n = 0;
    while (bus.busy && n < 3000) begin tick(); n++; end
    check("idle_reached", bus.busy, 0);
    ic = cyc;
  endtask

  // One ping on sensor s: optional stale high across WAIT_RISE entry, then a
  // pulse of 'width' cycles starting 'gap' cycles later (width 0 = no echo).
  task automatic ping(input int s, input int gap, input int width, input bit stale,
                      output int tf);
    res_t e;
    int   w;
    wait_trig_rise(s);
    if (stale) bus.echo[s] = 1'b1;
    wait_trig_fall(s, tf);
    if (stale) begin
      repeat (5) tick();
      bus.echo[s] = 1'b0;
      repeat (4) tick();
    end
    repeat (gap) tick();
    e.id = s;
    if (width == 0) begin
      e.cycles = 0; e.to = 1'b1; e.at = tf + TMO + 1;
      exp_q.push_back(e);
    end else begin
      w = (width > TMO) ? TMO : width;
      e.cycles = w; e.to = (width > TMO); e.at = cyc + w + 4;
      exp_q.push_back(e);
      bus.echo[s] = 1'b1;
      repeat (width) tick();
      bus.echo[s] = 1'b0;
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    bus.echo = '0;
    exp_q.delete();
    #1;
    check("async_trig", bus.trig, 0);
    check("async_busy", bus.busy, 0);
    check("async_valid", bus.result_valid, 0);
    check("async_id", bus.result_id, 0);
    check("async_cycles", bus.result_cycles, 0);
    check("async_timeout", bus.result_timeout, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int   tf, ic, rises, base;
    res_t o;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.start  = 1'b0;
    bus.echo   = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("init_busy", bus.busy, 0);

    // 1: single shot, 20-cycle echo 6 cycles after trigger
    start_pulse();
    ping(0, 6, 20, 1'b0, tf);
    wait_results(1);
    o = obs_q[0];
    check("t1_id", o.id, 0);
    check("t1_cycles", o.cycles, 20);
    check("t1_timeout", o.to, 0);
    check("t1_trig_width", last_tw, 4);
    wait_idle(ic);

    // 2: no echo -> rise timeout; a start during the ping is dropped
    start_pulse();
    ping(1, 0, 0, 1'b0, tf);
    start_pulse();
    rises = n_rise;
    wait_results(2);
    o = obs_q[1];
    check("t2_id", o.id, 1);
    check("t2_cycles", o.cycles, 0);
    check("t2_timeout", o.to, 1);
    check("t2_latency", o.at - tf, 51);
    wait_idle(ic);
    check("t2_holdoff_len", ic - o.at, 10);
    repeat (30) tick();
    check("t2_start_ignored", n_rise - rises, 0);

    // 3: echo stuck high -> saturated measurement
    start_pulse();
    ping(0, 3, 100, 1'b0, tf);
    wait_results(3);
    o = obs_q[2];
    check("t3_id", o.id, 0);
    check("t3_cycles", o.cycles, 50);
    check("t3_timeout", o.to, 1);
    wait_idle(ic);

    // 5a: reset in the middle of MEASURE on sensor 1
    start_pulse();
    wait_trig_rise(1);
    wait_trig_fall(1, tf);
    repeat (2) tick();
    bus.echo[1] = 1'b1;
    repeat (10) tick();
    check("t5_busy_before", bus.busy, 1);
    check("t5_cycles_before", bus.result_cycles, 50);
    do_reset();
    repeat (20) tick();
    check("t5_idle_busy", bus.busy, 0);
    check("t5_idle_trig", bus.trig, 0);

    // 5b: reset while the trigger is high
    start_pulse();
    check("t5_trig_on", bus.trig, 1);
    do_reset();

    // 4: continuous mode, widths 12/30/7; enable dropped during the third ping
    base = obs_q.size();
    bus.enable = 1'b1;
    ping(0, 2, 12, 1'b0, tf);
    ping(1, 5, 30, 1'b0, tf);
    wait_trig_rise(0);
    bus.enable = 1'b0;
    ping(0, 1, 7, 1'b0, tf);
    wait_results(base + 3);
    check("t4_id0", obs_q[base].id, 0);
    check("t4_cyc0", obs_q[base].cycles, 12);
    check("t4_id1", obs_q[base+1].id, 1);
    check("t4_cyc1", obs_q[base+1].cycles, 30);
    check("t4_id2", obs_q[base+2].id, 0);
    check("t4_cyc2", obs_q[base+2].cycles, 7);
    check("t4_to2", obs_q[base+2].to, 0);
    rises = n_rise;
    repeat (40) tick();
    check("t4_stays_idle", n_rise - rises, 0);
    check("t4_busy_low", bus.busy, 0);

    // 6: stale echo across WAIT_RISE entry, then a 15-cycle pulse
    do_reset();
    base = obs_q.size();
    start_pulse();
    ping(0, 3, 15, 1'b1, tf);
    wait_results(base + 1);
    check("t6_id", obs_q[base].id, 0);
    check("t6_cycles", obs_q[base].cycles, 15);
    check("t6_timeout", obs_q[base].to, 0);
    wait_idle(ic);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
